// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - load/store request, response and word-RAM bus bundle for mem_ctrl
interface mem_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_cs;
  logic              ram_rd;
  logic              ram_oe;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  // The master side is the MEM stage together with the RAM it fronts.
  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, ram_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  ram_addr, ram_cs, ram_rd, ram_oe, ram_wdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, ram_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output ram_addr, ram_cs, ram_rd, ram_oe, ram_wdata
  );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-addressed load/store front-end for a big-endian 32-bit word RAM
module mem_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic     clk,
  input  logic     rst_n,
  mem_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_RDW  = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              we_q, we_d;
  logic              signed_q, signed_d;
  logic              err_q, err_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       word_q, word_d;

  logic              accept;
  logic              req_err;
  logic [4:0]        lane_sh;
  logic [31:0]       word_sh;
  logic [31:0]       merged;
  logic [31:0]       loaded;

  assign accept = bus.req_valid && bus.req_ready;

  always_comb begin
    req_err = 1'b0;
    case (bus.req_size)
      2'b01:   req_err = bus.req_addr[0];
      2'b10:   req_err = (bus.req_addr[1:0] != 2'b00);
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
  end

  // Big-endian: offset 0 is the most significant lane, so the shift is the inverted offset.
  always_comb begin
    lane_sh = '0;
    merged  = wdata_q;
    loaded  = word_q;
    word_sh = '0;
    case (size_q)
      2'b00: begin
        lane_sh = {~addr_q[1:0], 3'b000};
        word_sh = word_q >> lane_sh;
        loaded  = signed_q ? {{24{word_sh[7]}}, word_sh[7:0]} : {24'b0, word_sh[7:0]};
        merged  = (word_q & ~(32'h0000_00FF << lane_sh)) | ({24'b0, wdata_q[7:0]} << lane_sh);
      end
      2'b01: begin
        lane_sh = addr_q[1] ? 5'd0 : 5'd16;
        word_sh = word_q >> lane_sh;
        loaded  = signed_q ? {{16{word_sh[15]}}, word_sh[15:0]} : {16'b0, word_sh[15:0]};
        merged  = (word_q & ~(32'h0000_FFFF << lane_sh)) | ({16'b0, wdata_q[15:0]} << lane_sh);
      end
      default: begin
        loaded = word_q;
        merged = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    we_d     = we_q;
    signed_d = signed_q;
    err_d    = err_q;
    wdata_d  = wdata_q;
    word_d   = word_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d   = bus.req_addr;
          size_d   = bus.req_size;
          we_d     = bus.req_we;
          signed_d = bus.req_signed;
          wdata_d  = bus.req_wdata;
          err_d    = req_err;
          if (req_err) begin
            state_d = S_RESP;
          end else if (bus.req_we && bus.req_size == 2'b10) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD:   state_d = S_RDW;
      S_RDW: begin
        word_d  = bus.ram_rdata;
        state_d = we_q ? S_WR : S_RESP;
      end
      S_WR:   state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      word_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      we_q     <= we_d;
      signed_q <= signed_d;
      err_q    <= err_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
    end
  end

  assign bus.req_ready  = rst_n && (state_q == S_IDLE);
  assign bus.ram_addr   = addr_q[ADDR_W+1:2];
  assign bus.ram_cs     = (state_q == S_RD) || (state_q == S_RDW) || (state_q == S_WR);
  assign bus.ram_rd     = (state_q == S_RD) || (state_q == S_RDW);
  assign bus.ram_oe     = (state_q == S_RD) || (state_q == S_RDW);
  assign bus.ram_wdata  = (state_q == S_WR) ? merged : 32'h0;
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_err   = (state_q == S_RESP) && err_q;
  assign bus.resp_rdata = ((state_q == S_RESP) && !we_q && !err_q) ? loaded : 32'h0;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - scoreboard bench for mem_ctrl with a synchronous-read RAM model
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_W(10)) bus ();
  mem_ctrl #(.ADDR_W(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {logic [31:0] rdata; logic err; int cyc;} resp_t;
  typedef struct {logic [9:0] addr; logic [31:0] data;} wr_t;

  logic [31:0] mem [0:1023];
  resp_t resp_q[$];
  wr_t   wr_q[$];
  int tests = 0, fails = 0, cyc = 0;
  int resp_cnt = 0, cs_cnt = 0, rd_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.ram_cs) begin
      if (bus.ram_rd) bus.ram_rdata <= mem[bus.ram_addr];
      else            mem[bus.ram_addr] <= bus.ram_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    resp_t re;
    wr_t   we;
    if (bus.ram_cs) cs_cnt++;
    if (bus.ram_cs && bus.ram_rd) rd_cnt++;
    if (bus.resp_valid) begin
      resp_cnt++;
      if (resp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected 0");
      end else begin
        re = resp_q.pop_front();
        check("resp_rdata", bus.resp_rdata, re.rdata);
        check("resp_err", 32'(bus.resp_err), 32'(re.err));
        check("resp_cycle", 32'(cyc), 32'(re.cyc));
      end
    end
    if (bus.ram_cs && !bus.ram_rd) begin
      if (wr_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_write: got write to %h expected none", bus.ram_addr);
      end else begin
        we = wr_q.pop_front();
        check("ram_addr", 32'(bus.ram_addr), 32'(we.addr));
        check("ram_wdata", bus.ram_wdata, we.data);
      end
    end
  end

  task automatic issue(input logic w, input logic [1:0] size, input logic sgn,
                       input logic [11:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                       input logic exp_wr, input logic [31:0] exp_word, input logic exp_resp);
    int waited = 0;
    @(negedge clk);
    while (!bus.req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) begin
      tests++; fails++;
      $display("FAIL ready_timeout: got req_ready=0 expected 1");
      return;
    end
    bus.req_we     = w;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    if (exp_resp) resp_q.push_back('{exp_rdata, exp_err, cyc + lat});
    if (exp_wr)   wr_q.push_back('{addr[11:2], exp_word});
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic load(input logic [1:0] size, input logic sgn, input logic [11:0] addr,
                      input logic [31:0] exp);
    issue(1'b0, size, sgn, addr, 32'h0, exp, 1'b0, 3, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic store(input logic [1:0] size, input logic [11:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_word, input int lat);
    issue(1'b1, size, 1'b0, addr, wd, 32'h0, 1'b0, lat, 1'b1, exp_word, 1'b1);
  endtask

  task automatic bad(input logic w, input logic [1:0] size, input logic [11:0] addr);
    issue(w, size, 1'b1, addr, 32'hDEAD_BEEF, 32'h0, 1'b1, 1, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((resp_q.size() != 0 || wr_q.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(resp_q.size() + wr_q.size()), 32'h0);
  endtask

  initial begin
    int c0, r0, w;
    logic [11:0] a6 [3];
    logic [1:0]  s6 [3];
    logic        g6 [3];
    logic [31:0] e6 [3];
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'h0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    check("rst_resp_err", 32'(bus.resp_err), 32'h0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check("rst_ram_ctl", {29'b0, bus.ram_cs, bus.ram_rd, bus.ram_oe}, 32'h0);
    check("rst_ram_wdata", bus.ram_wdata, 32'h0);
    rst_n = 1'b1;
    #1 check("rel_req_ready", 32'(bus.req_ready), 32'h1);

    store(2'b10, 12'h010, 32'h1122_3344, 32'h1122_3344, 2);
    store(2'b10, 12'h020, 32'h80FF_7F01, 32'h80FF_7F01, 2);
    load(2'b00, 1'b1, 12'h020, 32'hFFFF_FF80);
    load(2'b00, 1'b0, 12'h020, 32'h0000_0080);
    load(2'b01, 1'b1, 12'h022, 32'h0000_7F01);
    load(2'b01, 1'b1, 12'h020, 32'hFFFF_80FF);
    load(2'b01, 1'b0, 12'h020, 32'h0000_80FF);
    load(2'b00, 1'b1, 12'h023, 32'h0000_0001);
    load(2'b10, 1'b1, 12'h020, 32'h80FF_7F01);
    drain("drain_loads");

    r0 = rd_cnt;
    store(2'b00, 12'h011, 32'h0000_00AA, 32'h11AA_3344, 4);
    drain("drain_sb");
    check("sb_read_cycles", 32'(rd_cnt - r0), 32'd2);
    store(2'b01, 12'h012, 32'h0000_BEEF, 32'h11AA_BEEF, 4);
    store(2'b00, 12'h013, 32'hFFFF_FF55, 32'h11AA_BE55, 4);
    load(2'b10, 1'b0, 12'h010, 32'h11AA_BE55);
    drain("drain_sub_stores");

    c0 = cs_cnt;
    bad(1'b0, 2'b10, 12'h012);
    bad(1'b1, 2'b01, 12'h013);
    bad(1'b0, 2'b11, 12'h010);
    bad(1'b1, 2'b10, 12'h011);
    drain("drain_errors");
    check("err_no_ram_cs", 32'(cs_cnt - c0), 32'h0);

    r0 = resp_cnt;
    issue(1'b1, 2'b00, 1'b0, 12'h010, 32'h0000_0077, 32'h0, 1'b0, 4, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midop_req_ready_low", 32'(bus.req_ready), 32'h0);
    rst_n = 1'b1;
    #1 check("midop_req_ready_rel", 32'(bus.req_ready), 32'h1);
    repeat (6) @(negedge clk);
    check("midop_no_resp", 32'(resp_cnt - r0), 32'h0);
    check("midop_word_kept", mem[4], 32'h11AA_BE55);

    a6 = '{12'h020, 12'h021, 12'h010};
    s6 = '{2'b10, 2'b00, 2'b01};
    g6 = '{1'b1, 1'b0, 1'b1};
    e6 = '{32'h80FF_7F01, 32'h0000_00FF, 32'h0000_11AA};
    r0 = resp_cnt;
    @(negedge clk);
    bus.req_we = 1'b0;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.req_addr = a6[i]; bus.req_size = s6[i]; bus.req_signed = g6[i];
      w = 0;
      while (!bus.req_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      check("held_ready", 32'(bus.req_ready), 32'h1);
      resp_q.push_back('{e6[i], 1'b0, cyc + 3});
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    drain("drain_held");
    repeat (3) @(negedge clk);
    check("held_resp_count", 32'(resp_cnt - r0), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
